mem_stage: RTL and testbench

Pipeline stage directly downstream of the execute stage in the RV32IM core. It takes one instruction at a time from EX (the ALU result plus store data and the memory-op code) and runs any load or store against the data-memory port with a req/gnt/rvalid handshake. It aligns and sign- or zero-extends load data, then presents the result to write-back under a valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

---
 rtl/rv_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 66 ++++++
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and helpers for the memory stage
package rv_pkg;

  localparam int BYTE_LANES = 4;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LH   = 4'd2,
    LW   = 4'd3,
    LBU  = 4'd4,
    LHU  = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } mem_state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_load(input mem_op_t op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
    case (op)
      LH, LHU, SH: return addr_lo[0];
      LW, SW:      return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and lane extract/extension for loads
module lsu_align
  import rv_pkg::*;
(
  input  mem_op_t                       op,
  input  logic [1:0]                    addr_lo,
  input  logic [8*BYTE_LANES-1:0]       store_data,
  input  logic [8*BYTE_LANES-1:0]       rdata,
  output logic [BYTE_LANES-1:0]         be,
  output logic [8*BYTE_LANES-1:0]       wdata,
  output logic [8*BYTE_LANES-1:0]       load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Byte enables mark the lanes touched by the access; store data is replicated across lanes.
  always_comb begin
    be    = '0;
    wdata = '0;
    case (op)
      SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SH: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      SW: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      LB, LBU:  be = 4'b0001 << addr_lo;
      LH, LHU:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
      LW:       be = 4'b1111;
      default: ;
    endcase
  end

  // Pick the addressed byte and halfword lanes out of the returned word.
  always_comb begin
    load_byte = rdata[7:0];
    case (addr_lo)
      2'd0: load_byte = rdata[7:0];
      2'd1: load_byte = rdata[15:8];
      2'd2: load_byte = rdata[23:16];
      2'd3: load_byte = rdata[31:24];
      default: ;
    endcase
    load_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Sign- or zero-extend the selected lane to the full width.
  always_comb begin
    load_data = rdata;
    case (op)
      LB:      load_data = {{24{load_byte[7]}}, load_byte};
      LBU:     load_data = {24'h0, load_byte};
      LH:      load_data = {{16{load_half[15]}}, load_half};
      LHU:     load_data = {16'h0, load_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage; MISALIGN_TRAP_EN enables the misaligned-access trap
module mem_stage
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
  input  logic [DATA_WIDTH-1:0] ex_store_data_i,
  input  mem_op_t               ex_mem_op_i,
  input  logic [4:0]            ex_rd_i,
  input  logic                  ex_reg_write_i,
  output logic                  dmem_req_o,
  input  logic                  dmem_gnt_i,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [DATA_WIDTH-1:0] wb_result_o,
  output logic [4:0]            wb_rd_o,
  output logic                  wb_reg_write_o,
  output logic                  misalign_o
);

  mem_state_t            state;
  mem_state_t            state_next;
  mem_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] store_data_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [4:0]            rd_q;
  logic                  reg_write_q;
  logic                  misalign_q;
  logic                  misalign_in;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] load_data;

`ifdef MISALIGN_TRAP_EN
  assign misalign_in = is_misaligned(ex_mem_op_i, ex_alu_result_i[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  assign ex_ready_o = (state == IDLE) || ((state == DONE) && wb_ready_i);
  assign handshake  = ex_valid_i && ex_ready_o;

  lsu_align u_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (store_data_q),
    .rdata      (dmem_rdata_i),
    .be         (dmem_be_o),
    .wdata      (dmem_wdata_o),
    .load_data  (load_data)
  );

  assign dmem_req_o     = (state == REQ);
  assign dmem_we_o      = (state == REQ) && is_store(op_q);
  assign dmem_addr_o    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign wb_valid_o     = (state == DONE);
  assign wb_result_o    = result_q;
  assign wb_rd_o        = rd_q;
  assign wb_reg_write_o = reg_write_q;
  assign misalign_o     = misalign_q;

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a new instruction may enter in IDLE or in the same cycle DONE retires.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = ((ex_mem_op_i == NONE) || misalign_in) ? DONE : REQ;
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          state_next = is_store(op_q) ? DONE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (wb_ready_i) begin
          if (handshake) begin
            state_next = ((ex_mem_op_i == NONE) || misalign_in) ? DONE : REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the instruction on accept; overwrite the result with load data when it returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= NONE;
      addr_q       <= '0;
      store_data_q <= '0;
      result_q     <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else if (handshake) begin
      op_q         <= ex_mem_op_i;
      addr_q       <= ex_alu_result_i[ADDR_WIDTH-1:0];
      store_data_q <= ex_store_data_i;
      result_q     <= ex_alu_result_i;
      rd_q         <= ex_rd_i;
      reg_write_q  <= ex_reg_write_i && !is_store(ex_mem_op_i) && !misalign_in;
      misalign_q   <= misalign_in;
    end else if ((state == WAIT_RSP) && dmem_rvalid_i && is_load(op_q)) begin
      result_q     <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  mem_op_t     ex_mem_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_gnt;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid_i      (ex_valid),
    .ex_ready_o      (ex_ready),
    .ex_alu_result_i (ex_alu_result),
    .ex_store_data_i (ex_store_data),
    .ex_mem_op_i     (ex_mem_op),
    .ex_rd_i         (ex_rd),
    .ex_reg_write_i  (ex_reg_write),
    .dmem_req_o      (dmem_req),
    .dmem_gnt_i      (dmem_gnt),
    .dmem_we_o       (dmem_we),
    .dmem_addr_o     (dmem_addr),
    .dmem_be_o       (dmem_be),
    .dmem_wdata_o    (dmem_wdata),
    .dmem_rvalid_i   (dmem_rvalid),
    .dmem_rdata_i    (dmem_rdata),
    .wb_valid_o      (wb_valid),
    .wb_ready_i      (wb_ready),
    .wb_result_o     (wb_result),
    .wb_rd_o         (wb_rd),
    .wb_reg_write_o  (wb_reg_write),
    .misalign_o      (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input mem_op_t op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_reg_write  = rw;
  endtask

  // Accept a load, grant at once, return data one cycle later; a stray rvalid rides the gnt cycle.
  task automatic do_load(input mem_op_t op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd);
    present(op, addr, 32'h0, rd, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = ~data;
    step();
    dmem_gnt    = 1'b0;
    chk("ld_wait_no_valid", wb_valid, 0);
    dmem_rdata  = data;
    step();
    dmem_rvalid = 1'b0;
    chk("ld_done_valid", wb_valid, 1);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_op = NONE; ex_alu_result = '0; ex_store_data = '0;
    ex_rd = '0; ex_reg_write = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dmem_rdata = '0; wb_ready = 1'b1;
    step(); step();
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    rst = 1'b0;
    step();

    // NONE passes through with one cycle of latency
    present(NONE, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("none_valid", wb_valid, 1);
    chk("none_result", wb_result, 32'h0000_1234);
    chk("none_rd", wb_rd, 5);
    chk("none_rw", wb_reg_write, 1);
    chk("none_misalign", misalign, 0);
    step();
    chk("none_idle", wb_valid, 0);

    // SB to 0x103 with gnt held off two cycles
    present(SB, 32'h0000_0103, 32'h0000_00AB, 5'd1, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("sb_req", dmem_req, 1);
    chk("sb_we", dmem_we, 1);
    chk("sb_addr", dmem_addr, 32'h0000_0100);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("sb_req_hold", dmem_req, 1);
      chk("sb_addr_hold", dmem_addr, 32'h0000_0100);
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("sb_req_drop", dmem_req, 0);
    chk("sb_done", wb_valid, 1);
    chk("sb_rw", wb_reg_write, 0);
    step();

    // SH to 0x106 uses the upper halfword lanes
    present(SH, 32'h0000_0106, 32'h1234_ABCD, 5'd2, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("sh_addr", dmem_addr, 32'h0000_0104);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("sh_done", wb_valid, 1);
    step();

    // Load extension cases
    do_load(LB, 32'h0000_0102, 32'h0080_0000, 5'd7);
    chk("lb_result", wb_result, 32'hFFFF_FF80);
    chk("lb_rd", wb_rd, 7);
    chk("lb_rw", wb_reg_write, 1);
    step();
    do_load(LBU, 32'h0000_0102, 32'h0080_0000, 5'd8);
    chk("lbu_result", wb_result, 32'h0000_0080);
    step();
    do_load(LH, 32'h0000_0100, 32'h0000_8001, 5'd9);
    chk("lh_result", wb_result, 32'hFFFF_8001);
    step();

    // Back-to-back loads with write-back stalled three cycles
    wb_ready = 1'b0;
    present(LW, 32'h0000_0300, 32'h0, 5'd3, 1'b1);
    step();
    present(LHU, 32'h0000_0402, 32'h0, 5'd4, 1'b1);
    chk("b2b_busy_req", ex_ready, 0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h1122_3344;
    step();
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_hold_valid", wb_valid, 1);
      chk("b2b_hold_result", wb_result, 32'h1122_3344);
      chk("b2b_hold_ready", ex_ready, 0);
      if (i < 2) step();
    end
    step();
    wb_ready = 1'b1;
    #1;
    chk("b2b_ready_rise", ex_ready, 1);
    step();
    ex_valid = 1'b0;
    chk("b2b_second_req", dmem_req, 1);
    chk("b2b_second_addr", dmem_addr, 32'h0000_0400);
    chk("b2b_no_valid", wb_valid, 0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hBEEF_0000;
    step();
    dmem_rvalid = 1'b0;
    chk("b2b_second_result", wb_result, 32'h0000_BEEF);
    chk("b2b_second_rd", wb_rd, 4);
    step();

    // LW to a misaligned address
    present(LW, 32'h0000_0202, 32'h0, 5'd10, 1'b1);
    step();
    ex_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    chk("mis_no_req", dmem_req, 0);
    chk("mis_valid", wb_valid, 1);
    chk("mis_flag", misalign, 1);
    chk("mis_result", wb_result, 32'h0000_0202);
    chk("mis_rw", wb_reg_write, 0);
    step();
`else
    chk("mis_req", dmem_req, 1);
    chk("mis_addr", dmem_addr, 32'h0000_0200);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 1'b0;
    chk("mis_result", wb_result, 32'hCAFE_F00D);
    chk("mis_flag", misalign, 0);
    step();
`endif

    // Reset while waiting for load data
    present(LW, 32'h0000_0504, 32'h0, 5'd6, 1'b1);
    step();
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_ex_ready", ex_ready, 1);
    chk("mrst_req", dmem_req, 0);
    chk("mrst_we", dmem_we, 0);
    chk("mrst_valid", wb_valid, 0);
    chk("mrst_rw", wb_reg_write, 0);
    chk("mrst_misalign", misalign, 0);
    chk("mrst_addr", dmem_addr, 0);
    chk("mrst_be", dmem_be, 0);
    chk("mrst_wdata", dmem_wdata, 0);
    chk("mrst_result", wb_result, 0);
    chk("mrst_rd", wb_rd, 0);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    step();
    rst = 1'b0;
    step();
    dmem_rvalid = 1'b0;
    chk("mrst_rvalid_ignored", wb_valid, 0);
    chk("mrst_result_kept", wb_result, 0);
    present(NONE, 32'h0000_0055, 32'h0, 5'd9, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("post_rst_valid", wb_valid, 1);
    chk("post_rst_result", wb_result, 32'h0000_0055);
    chk("post_rst_rd", wb_rd, 9);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
